button_event_decoder: RTL
=========================

Name: button_event_decoder

Overview:
Consumes the debounced level from the debouncer (its signal_out drives this block's signal_in) and classifies button activity into single-cycle event pulses: press, release, short press, long press and double click. It also provides a held-level flag.
- One FSM plus one shared interval counter.
- All outputs registered.
- Sits between the debouncer and the user-interface or control logic.

Parameters:
LONG_CYCLES, 50000000, clk cycles a press must last to count as long (>=2)
DCLICK_CYCLES, 12500000, clk cycles after a short release within which a second press makes a double click (>=2)
REPEAT_CYCLES, 10000000, auto-repeat period while long-held (only with BTN_REPEAT_EN)
CNT_W, 32, counter width; must hold max(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
signal_in  input  1  debounced button level, 1 = pressed
press_pulse  output  1  one cycle on every press (rising edge)
release_pulse  output  1  one cycle on every release (falling edge)
short_press  output  1  one cycle when a short press is confirmed (no second press followed)
long_press  output  1  one cycle when a press reaches LONG_CYCLES
double_click  output  1  one cycle on release of the second press
held  output  1  level, 1 while in LONG_HELD
repeat_pulse  output  1  auto-repeat strobe; constant 0 without BTN_REPEAT_EN

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, cnt=0, all outputs 0.
  - sig_d loads signal_in every reset cycle, so a button held across reset release produces no press until it is released and pressed again.
- Edges: rise = signal_in & ~sig_d; fall = ~signal_in & sig_d; sig_d <= signal_in every cycle.
- Outputs are registered: an event decided at edge k is high for exactly the cycle following edge k.
- press_pulse and release_pulse fire on every rise or fall, in any state.
- IDLE: on rise, go to PRESSED with cnt=0.
- PRESSED, entered at edge k:
  - fall at edge k+j, 1<=j<=LONG_CYCLES: go to WAIT_SECOND with cnt=0.
  - signal_in still 1 at edge k+LONG_CYCLES: go to LONG_HELD and pulse long_press.
  - Release has priority over the long timeout at the same edge.
- LONG_HELD: held=1; on fall, go to IDLE with held=0 in the next cycle. No short_press or double_click is generated.
- WAIT_SECOND, entered at edge r:
  - rise at edge r+j, 1<=j<=DCLICK_CYCLES: go to SECOND_PRESSED.
  - signal_in still 0 at edge r+DCLICK_CYCLES: pulse short_press and go to IDLE.
  - Rise has priority over the timeout at the same edge.
- SECOND_PRESSED: on fall, pulse double_click and go to IDLE. Hold duration is irrelevant; long_press never fires here.
- Counter: saturating at the compare value, never wraps; cleared on every state change.
- Illegal state encodings recover to IDLE on the next edge.
- Reset mid-operation: any pending short, long or double event is discarded with no pulse.
- Simultaneous pulses are allowed:
  - release_pulse with double_click.
  - press_pulse with the SECOND_PRESSED entry.

Optional Feature:
BTN_REPEAT_EN:
- When defined, LONG_HELD reuses cnt: repeat_pulse fires REPEAT_CYCLES after entry to LONG_HELD, then every REPEAT_CYCLES while held.
- The first repeat is never coincident with long_press.
- A fall stops repeats immediately; no pulse is issued on the release edge.
- When not defined, repeat_pulse is tied 0 and no repeat logic is synthesized.

Test Plan:
Use LONG_CYCLES=8, DCLICK_CYCLES=6, REPEAT_CYCLES=4, clk period 20 ns; edge numbers are relative to the first rise sampled at edge 0.
1. Rise at 0, fall at 3, no further activity -> press_pulse cycle after 0, release_pulse after 3, short_press after 9, nothing else.
2. Rise at 0, held to 20 -> long_press after 8, held=1 from after 8 until after the fall at 20, release_pulse after 20, no short_press.
3. Rise at 0, fall at 2, rise at 5, fall at 7 -> double_click and release_pulse both after 7, no short_press.
4. Boundaries:
   - Fall exactly at edge 8 -> short path, no long_press.
   - Second rise exactly at edge r+6 -> double-click path.
5. signal_in=1 during reset, rst_n released, held 30 cycles -> no outputs; then release and press -> normal press_pulse. Separately, assert reset at edge 4 of a press -> all outputs 0, no short or long pulse ever.
6. Repeat:
   - BTN_REPEAT_EN defined, hold 20 cycles -> long_press after 8, repeat_pulse after 12 and 16, none after the release at 20.
   - Without the macro -> repeat_pulse stays 0 throughout.

Source files
------------

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into press/release/short/long/double-click pulses.
// Optional auto-repeat while long-held is enabled by defining BTN_REPEAT_EN.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int DCLICK_CYCLES = 12500000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic signal_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held,
  output logic repeat_pulse
);

  localparam logic [2:0] IDLE           = 3'd0;
  localparam logic [2:0] PRESSED        = 3'd1;
  localparam logic [2:0] LONG_HELD      = 3'd2;
  localparam logic [2:0] WAIT_SECOND    = 3'd3;
  localparam logic [2:0] SECOND_PRESSED = 3'd4;

  // cnt is cleared on state entry, so the timeout edge sees cnt == N-1
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

  if (LONG_CYCLES < 2 || DCLICK_CYCLES < 2 || REPEAT_CYCLES < 1 ||
      CNT_W < $clog2(LONG_CYCLES + 1) || CNT_W < $clog2(DCLICK_CYCLES + 1) ||
      CNT_W < $clog2(REPEAT_CYCLES + 1)) begin : g_bad_cfg
    $error("button_event_decoder: illegal parameter combination");
  end

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             sig_d, rise, fall;
  logic             short_nx, long_nx, dbl_nx;

  assign rise = signal_in & ~sig_d;
  assign fall = ~signal_in & sig_d;

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic rep_nx;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    short_nx = 1'b0;
    long_nx  = 1'b0;
    dbl_nx   = 1'b0;
`ifdef BTN_REPEAT_EN
    rep_nx   = 1'b0;
`endif
    case (state)
      IDLE: if (rise) state_nx = PRESSED;
      PRESSED: begin
        if (fall) state_nx = WAIT_SECOND;
        else if (cnt >= LONG_LAST) begin
          state_nx = LONG_HELD;
          long_nx  = 1'b1;
        end else cnt_nx = cnt + CNT_W'(1);
      end
      LONG_HELD: begin
        if (fall) state_nx = IDLE;
`ifdef BTN_REPEAT_EN
        // repeat period restarts in place; the release edge wins over a due strobe
        else if (cnt >= REPEAT_LAST) begin
          rep_nx = 1'b1;
          cnt_nx = '0;
        end else cnt_nx = cnt + CNT_W'(1);
`endif
      end
      WAIT_SECOND: begin
        if (rise) state_nx = SECOND_PRESSED;
        else if (cnt >= DCLICK_LAST) begin
          state_nx = IDLE;
          short_nx = 1'b1;
        end else cnt_nx = cnt + CNT_W'(1);
      end
      SECOND_PRESSED: begin
        if (fall) begin
          state_nx = IDLE;
          dbl_nx   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx != state) cnt_nx = '0;
  end

  always_ff @(posedge clk) begin
    sig_d <= signal_in;
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_click  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_press   <= short_nx;
      long_press    <= long_nx;
      double_click  <= dbl_nx;
      held          <= (state_nx == LONG_HELD);
    end
  end

`ifdef BTN_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) repeat_pulse <= 1'b0;
    else        repeat_pulse <= rep_nx;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
